user_id_scanner: RTL and testbench
==================================

USER_ID_SCANNER -- requirements
Module: user_id_scanner

Interface
REQ-001 SHALL have parameter ID_W, default 16, width of a user ID word.
REQ-002 SHALL have parameter DEPTH, default 8, number of ID file entries (2..256).
REQ-003 SHALL have parameter ADDR_W, default 3, ID file address width, with DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 2, number of clock edges from rom_addr change to the compare of that entry (1..4).
REQ-005 SHALL have parameter MAX_FAIL, default 3, consecutive failed scans that trigger lockout.
REQ-006 SHALL have parameter LOCK_CYC, default 16, lockout duration in clocks.
REQ-007 SHALL have parameter SKIP_ZERO, default 1; when 1, an all-zero entry is an empty slot and never matches.
REQ-008 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-010 SHALL have port id_output, input, ID_W, the entered user ID.
REQ-011 SHALL have port user_allow, input, 1, scan request, level-sampled.
REQ-012 SHALL have port q_uid, input, ID_W, ID file read data.
REQ-013 SHALL have port address_user, output, ADDR_W, ID file read address.
REQ-014 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at scan completion.
REQ-016 SHALL have port pass_allow, output, 1, result of the last completed scan (1 = match).
REQ-017 SHALL have port match_idx, output, ADDR_W, index of the matching entry.
REQ-018 SHALL have port locked, output, 1, high during lockout.
REQ-019 SHALL have port fail_cnt, output, 8, current consecutive-failure count.

Function
REQ-020 SHALL implement states IDLE, SCAN, LOCK.
REQ-021 In IDLE, user_allow=1 at edge E0 SHALL do the following: latch id_output into an internal ID register, set address_user=0, clear pass_allow, enter SCAN with busy=1.
REQ-022 In SCAN, address_user SHALL increment by 1 per clock up to DEPTH-1 and then hold; id_output changes during SCAN SHALL be ignored.
REQ-023 Entry i SHALL be compared against the latched ID at edge E0+i+RD_LAT, using a valid/index pipeline RD_LAT deep.
REQ-024 On the first match at index i: pass_allow=1, match_idx=i, done=1 for the one cycle after the compare edge, fail_cnt cleared, return to IDLE; later entries SHALL NOT be compared.
REQ-025 If no match exists: at edge E0+DEPTH-1+RD_LAT, pass_allow=0, match_idx=0, done pulse, fail_cnt+1 (saturating at 255).
REQ-026 If the incremented fail_cnt reaches MAX_FAIL, the block SHALL enter LOCK, otherwise IDLE.
REQ-027 LOCK SHALL assert locked=1 for exactly LOCK_CYC clocks, ignore user_allow, then clear fail_cnt and enter IDLE.
REQ-028 Duplicate IDs in the file SHALL report the lowest index.
REQ-029 When SKIP_ZERO=1, a zero-valued ID never passes, even if present in the file.
REQ-030 pass_allow and match_idx SHALL hold until the next accepted user_allow or reset.
REQ-031 user_allow held high SHALL start a new scan on the first IDLE cycle after done (back-to-back scans).
REQ-032 busy SHALL be 0 in IDLE and LOCK; done and busy SHALL never be high in the same cycle.

Reset
REQ-033 rst=0 at a rising edge SHALL set state IDLE, address_user=0, busy=0, done=0, pass_allow=0, match_idx=0, locked=0, fail_cnt=0, and clear the pipeline valid bits.
REQ-034 Reset mid-SCAN or mid-LOCK SHALL abort with no done pulse; the first user_allow after release is accepted normally.

Verification (ID_W=16, DEPTH=8, RD_LAT=2, MAX_FAIL=3, LOCK_CYC=16; file[5]=16'hCCC3, file[6]=16'hCCC3, file[7]=0)
REQ-035 Match: id_output=16'hCCC3 with a 1-cycle user_allow at E0 -> done at E0+7, pass_allow=1, match_idx=5, fail_cnt=0.
REQ-036 Miss: id_output=16'h1234 -> done at E0+9, pass_allow=0, fail_cnt increments by 1, address_user holds at 7.
REQ-037 Lockout: three misses -> locked=1 for 16 cycles, user_allow ignored, then fail_cnt=0 and the next request accepted.
REQ-038 Zero ID: id_output=0 -> no match, pass_allow=0 (entry 7 skipped).
REQ-039 Reset abort: rst=0 at E0+3 of a scan -> all outputs at reset values, no done pulse; a rescan of 16'hCCC3 passes.
REQ-040 Back-to-back: user_allow held high -> a second scan starts the cycle after done, and pass_allow is cleared at its start.

Source files
------------

// File: rtl/user_id_scanner.sv
// user_id_scanner: sequential search of an external ID file for an entered user ID.
// The entered ID is latched on request, ID file entries are fetched one per clock
// and compared after RD_LAT edges. Consecutive failed scans lead to a timed lockout.
// Ports:
//   clk, rst (sync, active-low)     clock and reset
//   id_output, user_allow           entered ID and level-sampled scan request
//   q_uid / address_user            ID file read data / read address
//   busy, done                      scan in progress / one-cycle completion pulse
//   pass_allow, match_idx           result and matching index of last scan
//   locked, fail_cnt                lockout active / consecutive failure count
module user_id_scanner #(
  parameter int unsigned ID_W      = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MAX_FAIL  = 3,
  parameter int unsigned LOCK_CYC  = 16,
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   id_output,
  input  logic              user_allow,
  input  logic [ID_W-1:0]   q_uid,
  output logic [ADDR_W-1:0] address_user,
  output logic              busy,
  output logic              done,
  output logic              pass_allow,
  output logic [ADDR_W-1:0] match_idx,
  output logic              locked,
  output logic [7:0]        fail_cnt
);

  localparam int unsigned LCW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, LOCK} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] midx_q, midx_d;
  logic              locked_q, locked_d;
  logic [7:0]        fail_q, fail_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] idx_q [RD_LAT];
  logic [ADDR_W-1:0] idx_d [RD_LAT];

  logic              push;
  logic [ADDR_W-1:0] push_idx;
  logic              flush;
  logic              hit;
  logic              last_cmp;
  logic [7:0]        fail_inc;

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      midx_q     <= '0;
      locked_q   <= 1'b0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      vld_q      <= '0;
      for (int k = 0; k < RD_LAT; k++) idx_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      midx_q     <= midx_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      vld_q      <= vld_d;
      for (int k = 0; k < RD_LAT; k++) idx_q[k] <= idx_d[k];
    end
  end

  // Next-state, outputs and compare pipeline
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    midx_d     = midx_q;
    locked_d   = locked_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    push       = 1'b0;
    push_idx   = addr_q;
    flush      = 1'b0;

    // The tail stage carries the index whose data is on q_uid this cycle
    hit      = vld_q[RD_LAT-1] && (q_uid == id_q) &&
               !((SKIP_ZERO != 0) && (q_uid == '0));
    last_cmp = vld_q[RD_LAT-1] && (idx_q[RD_LAT-1] == LAST_ADDR);
    fail_inc = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (user_allow) begin
          id_d     = id_output;
          addr_d   = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = SCAN;
          push     = 1'b1;
          push_idx = '0;
        end
      end
      SCAN: begin
        if (addr_q != LAST_ADDR) begin
          addr_d   = addr_q + ADDR_W'(1);
          push     = 1'b1;
          push_idx = addr_q + ADDR_W'(1);
        end
        if (hit) begin
          pass_d  = 1'b1;
          midx_d  = idx_q[RD_LAT-1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          fail_d  = '0;
          flush   = 1'b1;
          state_d = IDLE;
        end else if (last_cmp) begin
          pass_d  = 1'b0;
          midx_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          fail_d  = fail_inc;
          flush   = 1'b1;
          if (fail_inc >= 8'(MAX_FAIL)) begin
            locked_d   = 1'b1;
            lock_cnt_d = LCW'(LOCK_CYC - 1);
            state_d    = LOCK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCK: begin
        if (lock_cnt_q == '0) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Valid/index shift register; flushed so no stale compare survives completion
    vld_d[0] = push && !flush;
    idx_d[0] = push_idx;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1] && !flush;
      idx_d[k] = idx_q[k-1];
    end
  end

  assign address_user = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_allow   = pass_q;
  assign match_idx    = midx_q;
  assign locked       = locked_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_user_id_scanner.sv
// Testbench for user_id_scanner: table vectors, hand sequences for lockout,
// reset abort and back-to-back scans, then randomized files and IDs against a
// search model.
module tb_user_id_scanner;
  localparam int unsigned ID_W     = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_FAIL = 3;
  localparam int unsigned LOCK_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ID_W-1:0]   id_output = '0;
  logic              user_allow = 1'b0;
  logic [ID_W-1:0]   q_uid = '0;
  logic [ADDR_W-1:0] address_user;
  logic              busy;
  logic              done;
  logic              pass_allow;
  logic [ADDR_W-1:0] match_idx;
  logic              locked;
  logic [7:0]        fail_cnt;

  user_id_scanner #(
    .ID_W(ID_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC), .SKIP_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .id_output(id_output), .user_allow(user_allow),
    .q_uid(q_uid), .address_user(address_user), .busy(busy), .done(done),
    .pass_allow(pass_allow), .match_idx(match_idx), .locked(locked),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // ID file with one registered read stage (RD_LAT = 2 from address to compare)
  logic [ID_W-1:0] mem [DEPTH];
  always @(posedge clk) q_uid <= mem[address_user];

  int checks = 0;
  int errors = 0;
  int model_fail = 0;

  typedef struct {
    logic [ID_W-1:0] id;
    bit              pass;
    int              idx;
    int              lat;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Search rule: lowest index equal to the ID, zero never matches
  function automatic void ref_scan(input logic [ID_W-1:0] id, output bit p,
                                   output int idx, output int lat);
    p   = 1'b0;
    idx = 0;
    lat = DEPTH - 1 + RD_LAT;
    for (int i = 0; i < DEPTH; i++) begin
      if (!p && id != '0 && mem[i] == id) begin
        p   = 1'b1;
        idx = i;
        lat = i + RD_LAT;
      end
    end
  endfunction

  // One-cycle request; returns number of edges from E0 to done (-1 on timeout)
  task automatic do_scan(input logic [ID_W-1:0] id, output int lat);
    id_output  = id;
    user_allow = 1'b1;
    tick;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pass_clr", 32'(pass_allow), 32'd0);
    user_allow = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      id_output = ID_W'($urandom);
      tick;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no done expected done within 40 cycles");
    end else begin
      chk("done_busy_excl", 32'(busy), 32'd0);
    end
  endtask

  task automatic update_fail(input bit p);
    if (p) model_fail = 0;
    else if (model_fail < 255) model_fail++;
  endtask

  task automatic check_lock;
    chk("lock_first", 32'(locked), 32'd1);
    user_allow = 1'b1;
    id_output  = 16'hCCC3;
    for (int k = 1; k < LOCK_CYC; k++) begin
      tick;
      chk("lock_hold", 32'(locked), 32'd1);
      chk("lock_busy", 32'(busy), 32'd0);
    end
    user_allow = 1'b0;
    tick;
    chk("lock_exit", 32'(locked), 32'd0);
    chk("lock_fail_clr", 32'(fail_cnt), 32'd0);
    model_fail = 0;
  endtask

  task automatic scan_and_check(input logic [ID_W-1:0] id);
    bit p;
    int idx;
    int lat;
    int got;
    ref_scan(id, p, idx, lat);
    do_scan(id, got);
    chk("rnd_lat", 32'(got), 32'(lat));
    chk("rnd_pass", 32'(pass_allow), 32'(p));
    chk("rnd_idx", 32'(match_idx), 32'(idx));
    update_fail(p);
    chk("rnd_fail", 32'(fail_cnt), 32'(model_fail));
    if (model_fail >= MAX_FAIL) check_lock();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    bool_dummy: begin end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'hCCC3; mem[6] = 16'hCCC3; mem[7] = 16'h0000;

    tbl[0] = '{16'hCCC3, 1'b1, 5, 7};
    tbl[1] = '{16'h1234, 1'b0, 0, 9};
    tbl[2] = '{16'h0000, 1'b0, 0, 9};
    tbl[3] = '{16'h1111, 1'b1, 0, 2};
    tbl[4] = '{16'h5555, 1'b1, 4, 6};

    // Reset state
    rst = 1'b0;
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_allow), 32'd0);
    chk("rst_idx", 32'(match_idx), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_addr", 32'(address_user), 32'd0);
    rst = 1'b1;
    tick;

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      do_scan(tbl[v].id, got);
      chk("tbl_lat", 32'(got), 32'(tbl[v].lat));
      chk("tbl_pass", 32'(pass_allow), 32'(tbl[v].pass));
      chk("tbl_idx", 32'(match_idx), 32'(tbl[v].idx));
      update_fail(tbl[v].pass);
      chk("tbl_fail", 32'(fail_cnt), 32'(model_fail));
      if (!tbl[v].pass) chk("tbl_addr_hold", 32'(address_user), 32'(DEPTH - 1));
      tick;
      chk("tbl_result_hold", 32'(pass_allow), 32'(tbl[v].pass));
    end

    // Lockout after three consecutive misses, then a normal request
    scan_and_check(16'h1234);
    scan_and_check(16'h9999);
    scan_and_check(16'h0000);
    scan_and_check(16'hCCC3);

    // Reset in the middle of a scan
    scan_and_check(16'h7777);
    id_output  = 16'hCCC3;
    user_allow = 1'b1;
    tick;
    user_allow = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_fail", 32'(fail_cnt), 32'd0);
    chk("abort_addr", 32'(address_user), 32'd0);
    chk("abort_locked", 32'(locked), 32'd0);
    rst = 1'b1;
    model_fail = 0;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (done || busy) got++;
    end
    chk("abort_no_done", 32'(got), 32'd0);
    scan_and_check(16'hCCC3);

    // Back-to-back scans with user_allow held high
    id_output  = 16'hCCC3;
    user_allow = 1'b1;
    tick;
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (done) begin
        got = n;
        break;
      end
    end
    chk("b2b_lat1", 32'(got), 32'd7);
    chk("b2b_pass1", 32'(pass_allow), 32'd1);
    tick;
    chk("b2b_restart", 32'(busy), 32'd1);
    chk("b2b_pass_clr", 32'(pass_allow), 32'd0);
    user_allow = 1'b0;
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (done) begin
        got = n;
        break;
      end
    end
    chk("b2b_lat2", 32'(got), 32'd7);
    chk("b2b_pass2", 32'(pass_allow), 32'd1);
    chk("b2b_idx2", 32'(match_idx), 32'd5);
    model_fail = 0;
    tick;

    // Randomized files and IDs
    for (int r = 0; r < 40; r++) begin
      logic [ID_W-1:0] id;
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(3))
          0:       mem[i] = '0;
          1:       mem[i] = 16'hA000 + ID_W'($urandom_range(3));
          default: mem[i] = ID_W'($urandom);
        endcase
      end
      case ($urandom_range(3))
        0:       id = mem[$urandom_range(DEPTH - 1)];
        1:       id = 16'hA000 + ID_W'($urandom_range(3));
        2:       id = '0;
        default: id = ID_W'($urandom);
      endcase
      scan_and_check(id);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
